// File: rtl/axi4_sram_burst.sv
// rtl/axi4_sram_burst.sv - AXI4 burst slave in front of a single-port SRAM scratchpad
// Optional: AXI4_SRAM_BURST_RANGE_CHK_EN flags word indices >= WORD_DEPTH with SLVERR instead of wrapping.
module axi4_sram_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_DEPTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter bit RD_FIRST   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [7:0]              awlen_i,
  input  logic [1:0]              awburst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [7:0]              arlen_i,
  input  logic [1:0]              arburst_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = ADDR_WIDTH - BYTE_SH;
  localparam int MEM_AW  = $clog2(WORD_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

  state_t                r_state;
  logic                  r_ptr;
  logic                  r_awready, r_arready, r_wready, r_bvalid, r_rvalid, r_rlast;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic                  r_wrap_bad, r_werr;
  logic [DATA_WIDTH-1:0] r_mem [WORD_DEPTH];

  logic                  w_grant_w, w_grant_r, w_aw_hs, w_ar_hs, w_w_hs;
  logic                  w_last_beat, w_out_of_range, w_beat_err;
  logic [IDX_W-1:0]      w_next_idx, w_wrap_mask;
  logic [MEM_AW-1:0]     w_mem_addr;
  logic                  w_unused_addr;

  function automatic logic wrap_bad(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b10) &&
           !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
  endfunction

  // r_ptr=1 gives the read side priority when both requests are pending
  assign w_grant_w   = awvalid_i && (!arvalid_i || !r_ptr);
  assign w_grant_r   = arvalid_i && (!awvalid_i || r_ptr);
  assign w_aw_hs     = awvalid_i && r_awready;
  assign w_ar_hs     = arvalid_i && r_arready;
  assign w_w_hs      = wvalid_i && r_wready;
  assign w_last_beat = (r_cnt == r_len);
  assign w_mem_addr  = r_idx[MEM_AW-1:0];
  assign w_wrap_mask = {{(IDX_W-8){1'b0}}, r_len};
  assign w_unused_addr = ^{awaddr_i[BYTE_SH-1:0], araddr_i[BYTE_SH-1:0]};

`ifdef AXI4_SRAM_BURST_RANGE_CHK_EN
  assign w_out_of_range = |r_idx[IDX_W-1:MEM_AW];
`else
  assign w_out_of_range = 1'b0;
`endif

  assign w_beat_err = r_wrap_bad || w_out_of_range;

  always_comb begin
    w_next_idx = r_idx;
    case (r_burst)
      2'b00:   w_next_idx = r_idx;
      2'b10:   w_next_idx = (r_idx & ~w_wrap_mask) | ((r_idx + IDX_W'(1)) & w_wrap_mask);
      default: w_next_idx = r_idx + IDX_W'(1);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_WDATA && w_w_hs && !w_beat_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) r_mem[w_mem_addr][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_ptr      <= RD_FIRST;
      r_awready  <= 1'b0;
      r_arready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_bresp    <= 2'b00;
      r_rresp    <= 2'b00;
      r_rdata    <= '0;
      r_idx      <= '0;
      r_len      <= 8'd0;
      r_cnt      <= 8'd0;
      r_burst    <= 2'b00;
      r_wrap_bad <= 1'b0;
      r_werr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_awready  <= 1'b0;
            r_arready  <= 1'b0;
            r_wready   <= 1'b1;
            r_idx      <= awaddr_i[ADDR_WIDTH-1:BYTE_SH];
            r_len      <= awlen_i;
            r_burst    <= awburst_i;
            r_cnt      <= 8'd0;
            r_werr     <= 1'b0;
            r_wrap_bad <= wrap_bad(awburst_i, awlen_i);
            r_ptr      <= ~r_ptr;
            r_state    <= S_WDATA;
          end else if (w_ar_hs) begin
            r_awready  <= 1'b0;
            r_arready  <= 1'b0;
            r_idx      <= araddr_i[ADDR_WIDTH-1:BYTE_SH];
            r_len      <= arlen_i;
            r_burst    <= arburst_i;
            r_cnt      <= 8'd0;
            r_wrap_bad <= wrap_bad(arburst_i, arlen_i);
            r_ptr      <= ~r_ptr;
            r_state    <= S_RDATA;
          end else begin
            r_awready <= w_grant_w;
            r_arready <= w_grant_r;
          end
        end
        S_WDATA: begin
          if (w_w_hs) begin
            r_idx <= w_next_idx;
            r_cnt <= r_cnt + 8'd1;
            // the beat counter, not wlast_i, closes the burst
            if (w_last_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr || w_beat_err || !wlast_i) ? 2'b10 : 2'b00;
              r_state  <= S_WRESP;
            end else begin
              r_werr <= r_werr || w_beat_err || wlast_i;
            end
          end
        end
        S_WRESP: begin
          if (bready_i) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RDATA: begin
          if (r_rvalid && rready_i && r_rlast) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_state  <= S_IDLE;
          end else if (!r_rvalid || rready_i) begin
            r_rvalid <= 1'b1;
            r_rlast  <= w_last_beat;
            r_rdata  <= w_beat_err ? '0 : r_mem[w_mem_addr];
            r_rresp  <= w_beat_err ? 2'b10 : 2'b00;
            r_idx    <= w_next_idx;
            r_cnt    <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign awready_o = r_awready;
  assign arready_o = r_arready;
  assign wready_o  = r_wready;
  assign bvalid_o  = r_bvalid;
  assign bresp_o   = r_bresp;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign rresp_o   = r_rresp;
  assign rlast_o   = r_rlast;
endmodule
